// File: rtl/mhbf_cfg_sequencer.sv
// Streams per-stage configuration words from coefficient memory into the half-band filter chain.
// Optional build macro MHBF_CFG_CHECKSUM_EN: appends a checksum word to each stage and verifies it.
//
// state     | meaning
// IDLE      | waiting for Start
// SCAN      | skipping unselected stages
// FETCH     | memory read strobe for the current word
// RDWAIT    | capturing read data (or checking the checksum word)
// PRESENT   | word offered on isConfig until ACK
// WAIT_DONE | waiting for the stage to report done
// FINISH    | one-cycle Cfg_Done
// ERR       | latches Cfg_Err / Err_Stage
module mhbf_cfg_sequencer #(
    parameter int NMHBF_MAX       = 5,
    parameter int COEFF_WIDTH     = 24,
    parameter int WORDS_PER_STAGE = 35,
    parameter int ADDR_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   Start,
    input  logic [NMHBF_MAX-1:0]   Stage_Mask,
    input  logic                   Abort,
    output logic                   Mem_Rd,
    output logic [ADDR_WIDTH-1:0]  Mem_Addr,
    input  logic [COEFF_WIDTH-1:0] Mem_Rdata,
    output logic                   isConfig,
    output logic [COEFF_WIDTH-1:0] Data_Config_Out,
    input  logic                   isConfigACK,
    input  logic                   isConfigDone,
    output logic [3:0]             MHBF_CTL_idx,
    output logic                   Busy,
    output logic                   Cfg_Done,
    output logic                   Cfg_Err,
    output logic [3:0]             Err_Stage
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SCAN      = 3'd1;
    localparam logic [2:0] S_FETCH     = 3'd2;
    localparam logic [2:0] S_RDWAIT    = 3'd3;
    localparam logic [2:0] S_PRESENT   = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_FINISH    = 3'd6;
    localparam logic [2:0] S_ERR       = 3'd7;

`ifdef MHBF_CFG_CHECKSUM_EN
    localparam int STRIDE = WORDS_PER_STAGE + 1;
`else
    localparam int STRIDE = WORDS_PER_STAGE;
`endif
    localparam int WORD_W = $clog2(STRIDE + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [ADDR_WIDTH-1:0] STRIDE_A   = ADDR_WIDTH'(STRIDE);
    localparam logic [WORD_W-1:0]     LAST_WORD  = WORD_W'(WORDS_PER_STAGE - 1);
    localparam logic [3:0]            LAST_STAGE = 4'(NMHBF_MAX - 1);
    localparam logic [TMR_W-1:0]      TMR_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]             state_q, state_d;
    logic [NMHBF_MAX-1:0]   mask_q, mask_d;
    logic [3:0]             stage_q, stage_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [COEFF_WIDTH-1:0] data_q, data_d;
    logic                   err_q, err_d;
    logic [3:0]             err_stage_q, err_stage_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   stage_sel;
`ifdef MHBF_CFG_CHECKSUM_EN
    localparam logic [WORD_W-1:0] CHK_WORD = WORD_W'(WORDS_PER_STAGE);
    logic [COEFF_WIDTH-1:0] sum_q, sum_d;
`endif

    assign stage_sel = |(mask_q & ({{(NMHBF_MAX-1){1'b0}}, 1'b1} << stage_q));

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        stage_d     = stage_q;
        base_d      = base_q;
        word_d      = word_q;
        data_d      = data_q;
        err_d       = err_q;
        err_stage_d = err_stage_q;
        tmr_d       = (tmr_q != '0) ? tmr_q - TMR_W'(1) : tmr_q;
`ifdef MHBF_CFG_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    mask_d      = Stage_Mask;
                    err_d       = 1'b0;
                    err_stage_d = '0;
                    stage_d     = '0;
                    base_d      = '0;
                    state_d     = (Stage_Mask == '0) ? S_FINISH : S_SCAN;
                end
            end
            S_SCAN: begin
                if (stage_sel) begin
                    word_d  = '0;
`ifdef MHBF_CFG_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = S_FETCH;
                end else if (stage_q == LAST_STAGE) begin
                    state_d = S_FINISH;
                end else begin
                    stage_d = stage_q + 4'd1;
                    base_d  = base_q + STRIDE_A;
                end
            end
            S_FETCH: state_d = S_RDWAIT;
            S_RDWAIT: begin
`ifdef MHBF_CFG_CHECKSUM_EN
                // The checksum word is compared here and never presented.
                if (word_q == CHK_WORD) begin
                    state_d = (Mem_Rdata == sum_q) ? S_WAIT_DONE : S_ERR;
                end else begin
                    data_d  = Mem_Rdata;
                    state_d = S_PRESENT;
                end
`else
                data_d  = Mem_Rdata;
                state_d = S_PRESENT;
`endif
            end
            S_PRESENT: begin
                if (isConfigACK) begin
                    word_d = word_q + WORD_W'(1);
`ifdef MHBF_CFG_CHECKSUM_EN
                    sum_d  = sum_q + data_q;
                    state_d = S_FETCH;
`else
                    state_d = (word_q == LAST_WORD) ? S_WAIT_DONE : S_FETCH;
`endif
                end else if (tmr_q == '0) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT_DONE: begin
                if (isConfigDone) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_FINISH;
                    end else begin
                        stage_d = stage_q + 4'd1;
                        base_d  = base_q + STRIDE_A;
                        state_d = S_SCAN;
                    end
                end else if (tmr_q == '0) begin
                    state_d = S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides every other transition, including a pending error.
        if (Abort && (state_q != S_IDLE)) state_d = S_IDLE;
        if (state_d == S_ERR) begin
            err_d       = 1'b1;
            err_stage_d = stage_q;
        end
        if ((state_d != state_q) && ((state_d == S_PRESENT) || (state_d == S_WAIT_DONE)))
            tmr_d = TMR_LOAD;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            stage_q     <= '0;
            base_q      <= '0;
            word_q      <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            err_stage_q <= '0;
            tmr_q       <= '0;
`ifdef MHBF_CFG_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            stage_q     <= stage_d;
            base_q      <= base_d;
            word_q      <= word_d;
            data_q      <= data_d;
            err_q       <= err_d;
            err_stage_q <= err_stage_d;
            tmr_q       <= tmr_d;
`ifdef MHBF_CFG_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign Mem_Rd          = (state_q == S_FETCH);
    assign Mem_Addr        = base_q + ADDR_WIDTH'(word_q);
    assign isConfig        = (state_q == S_PRESENT);
    assign Data_Config_Out = data_q;
    assign MHBF_CTL_idx    = stage_q;
    assign Busy            = (state_q != S_IDLE) && (state_q != S_FINISH) && (state_q != S_ERR);
    assign Cfg_Done        = (state_q == S_FINISH);
    assign Cfg_Err         = err_q;
    assign Err_Stage       = err_stage_q;

endmodule

// File: tb/tb_mhbf_cfg_sequencer.sv
// Directed bench for mhbf_cfg_sequencer: vector table of configuration passes plus a memory/filter-chain model.
// Honours MHBF_CFG_CHECKSUM_EN the same way as the design.
module tb_mhbf_cfg_sequencer;

    localparam int WPS = 35;
`ifdef MHBF_CFG_CHECKSUM_EN
    localparam int STRIDE = WPS + 1;
`else
    localparam int STRIDE = WPS;
`endif

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        Start = 1'b0;
    logic [4:0]  Stage_Mask = '0;
    logic        Abort = 1'b0;
    logic        Mem_Rd;
    logic [7:0]  Mem_Addr;
    logic [23:0] Mem_Rdata;
    logic        isConfig;
    logic [23:0] Data_Config_Out;
    logic        isConfigACK = 1'b0;
    logic        isConfigDone = 1'b0;
    logic [3:0]  MHBF_CTL_idx;
    logic        Busy;
    logic        Cfg_Done;
    logic        Cfg_Err;
    logic [3:0]  Err_Stage;

    int n_cmp = 0;
    int n_fail = 0;
    logic [23:0] mem [0:255];

    typedef struct {
        logic [4:0] mask;
        int stall_word;
        int stall_cyc;
        int nodone_stage;
        int abort_word;
        int restart_word;
        int corrupt_stage;
        int exp_done;
        int exp_err;
        int exp_err_stage;
        int exp_err_lat;
    } vec_t;

    vec_t vecs[$];

    mhbf_cfg_sequencer dut (
        .CLK(CLK), .nRST(nRST), .Start(Start), .Stage_Mask(Stage_Mask), .Abort(Abort),
        .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr), .Mem_Rdata(Mem_Rdata),
        .isConfig(isConfig), .Data_Config_Out(Data_Config_Out),
        .isConfigACK(isConfigACK), .isConfigDone(isConfigDone),
        .MHBF_CTL_idx(MHBF_CTL_idx), .Busy(Busy), .Cfg_Done(Cfg_Done),
        .Cfg_Err(Cfg_Err), .Err_Stage(Err_Stage)
    );

    always #5 CLK = ~CLK;

    // Synchronous coefficient memory: data one cycle after the read strobe.
    always @(posedge CLK) if (Mem_Rd) Mem_Rdata <= mem[Mem_Addr];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] mask, input int stall_word, input int stall_cyc,
                                input int nodone, input int abort_word, input int restart_word,
                                input int corrupt, input int exp_done, input int exp_err,
                                input int exp_err_stage, input int exp_err_lat);
        vec_t v;
        v.mask = mask; v.stall_word = stall_word; v.stall_cyc = stall_cyc;
        v.nodone_stage = nodone; v.abort_word = abort_word; v.restart_word = restart_word;
        v.corrupt_stage = corrupt; v.exp_done = exp_done; v.exp_err = exp_err;
        v.exp_err_stage = exp_err_stage; v.exp_err_lat = exp_err_lat;
        return v;
    endfunction

    task automatic run_pass(input int vi, input vec_t v);
        int exp_addr[$], exp_data[$], exp_idx[$];
        int got_addr[$], got_data[$], got_idx[$];
        int nw, wcnt, stage_w, done_timer, stall_left, hi_run, max_run, dones;
        int err_cyc, last_ack, abort_cyc, end_cyc, exp_run, a;
        bit stop, fin, restarted;

        nw = 0; stop = 0;
        for (int s = 0; s < 5; s++) begin
            if (!v.mask[s] || stop) continue;
            if ((v.exp_err != 0) && (s > v.exp_err_stage)) continue;
            for (int w = 0; w < STRIDE; w++) begin
                a = s * STRIDE + w;
                exp_addr.push_back(a);
                if (w < WPS) begin
                    if ((v.abort_word >= 0) && (nw == v.abort_word)) begin
                        stop = 1;
                        break;
                    end
                    exp_data.push_back(int'(mem[a]));
                    exp_idx.push_back(s);
                    nw++;
                end
            end
        end

        if (v.corrupt_stage >= 0) mem[v.corrupt_stage * STRIDE + WPS] ^= 24'h1;

        wcnt = 0; stage_w = 0; done_timer = 0; stall_left = v.stall_cyc; hi_run = 0; max_run = 0;
        dones = 0; err_cyc = -1; last_ack = -1; abort_cyc = -1; end_cyc = -1; fin = 0; restarted = 0;

        @(negedge CLK);
        Stage_Mask = v.mask;
        Start = 1'b1;
        for (int c = 0; c < 4000 && !fin; c++) begin
            @(negedge CLK);
            Start = 1'b0; Abort = 1'b0; isConfigACK = 1'b0; isConfigDone = 1'b0;
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) isConfigDone = 1'b1;
            end
            if (Mem_Rd) got_addr.push_back(int'(Mem_Addr));
            if (Cfg_Done) dones++;
            if (Cfg_Err && (err_cyc < 0)) err_cyc = c;
            if ((abort_cyc >= 0) && (c == abort_cyc + 1)) begin
                chk($sformatf("v%0d_abort_busy", vi), int'(Busy), 0);
                chk($sformatf("v%0d_abort_isconfig", vi), int'(isConfig), 0);
            end
            if (isConfig) begin
                if (wcnt < exp_data.size())
                    chk($sformatf("v%0d_present_w%0d", vi, wcnt), int'(Data_Config_Out), exp_data[wcnt]);
                hi_run++;
                if ((wcnt == v.stall_word) && (stall_left > 0)) begin
                    stall_left--;
                end else begin
                    isConfigACK = 1'b1;
                    got_data.push_back(int'(Data_Config_Out));
                    got_idx.push_back(int'(MHBF_CTL_idx));
                    wcnt++;
                    stage_w++;
                    last_ack = c;
                    if (stage_w == WPS) begin
                        stage_w = 0;
                        if (int'(MHBF_CTL_idx) != v.nodone_stage) done_timer = 4;
                    end
                end
            end else begin
                if (hi_run > max_run) max_run = hi_run;
                hi_run = 0;
            end
            if ((v.restart_word >= 0) && (wcnt == v.restart_word) && !restarted) begin
                Start = 1'b1;
                Stage_Mask = 5'b11111;
                restarted = 1;
            end
            if ((v.abort_word >= 0) && (wcnt == v.abort_word) && !isConfigACK && (abort_cyc < 0)) begin
                Abort = 1'b1;
                abort_cyc = c;
            end
            if ((end_cyc < 0) && (Cfg_Done || Cfg_Err)) end_cyc = c;
            if ((end_cyc >= 0) && (c == end_cyc + 3)) fin = 1;
            if ((abort_cyc >= 0) && (c == abort_cyc + 4)) fin = 1;
        end
        if (hi_run > max_run) max_run = hi_run;
        isConfigACK = 1'b0; isConfigDone = 1'b0; Abort = 1'b0; Start = 1'b0;
        if (!fin) begin
            n_cmp++;
            n_fail++;
            $display("FAIL v%0d_pass_end: got no end of pass expected end within 4000 cycles", vi);
        end

        if (v.corrupt_stage >= 0) mem[v.corrupt_stage * STRIDE + WPS] ^= 24'h1;

        chk($sformatf("v%0d_done_pulses", vi), dones, v.exp_done);
        chk($sformatf("v%0d_cfg_err", vi), int'(Cfg_Err), v.exp_err);
        chk($sformatf("v%0d_err_stage", vi), int'(Err_Stage), v.exp_err_stage);
        chk($sformatf("v%0d_busy_end", vi), int'(Busy), 0);
        if (v.exp_err_lat > 0)
            chk($sformatf("v%0d_err_latency", vi), err_cyc - last_ack, v.exp_err_lat);
        exp_run = (v.stall_cyc > 0) ? v.stall_cyc + 1 : ((exp_data.size() > 0) ? 1 : 0);
        chk($sformatf("v%0d_isconfig_run", vi), max_run, exp_run);
        chk($sformatf("v%0d_n_fetch", vi), got_addr.size(), exp_addr.size());
        chk($sformatf("v%0d_n_words", vi), got_data.size(), exp_data.size());
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
            chk($sformatf("v%0d_addr%0d", vi, i), got_addr[i], exp_addr[i]);
        for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
            chk($sformatf("v%0d_data%0d", vi, i), got_data[i], exp_data[i]);
            chk($sformatf("v%0d_idx%0d", vi, i), got_idx[i], exp_idx[i]);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = {a[7:0], 16'(a * 291) ^ 16'hBEEF};
`ifdef MHBF_CFG_CHECKSUM_EN
        for (int s = 0; s < 5; s++) begin
            logic [23:0] sum;
            sum = '0;
            for (int w = 0; w < WPS; w++) sum = sum + mem[s * STRIDE + w];
            mem[s * STRIDE + WPS] = sum;
        end
`endif

        repeat (3) @(negedge CLK);
        chk("rst_mem_rd", int'(Mem_Rd), 0);
        chk("rst_mem_addr", int'(Mem_Addr), 0);
        chk("rst_isconfig", int'(isConfig), 0);
        chk("rst_data", int'(Data_Config_Out), 0);
        chk("rst_idx", int'(MHBF_CTL_idx), 0);
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Cfg_Done), 0);
        chk("rst_err", int'(Cfg_Err), 0);
        chk("rst_err_stage", int'(Err_Stage), 0);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_busy", int'(Busy), 0);
        chk("idle_done", int'(Cfg_Done), 0);

        //           mask      stw  stc  nodone abort rst  corr done err estg lat
        vecs.push_back(mk(5'b00001, -1,  0, -1,   -1,   -1,  -1,  1,   0,  0,   0));
        vecs.push_back(mk(5'b10100, -1,  0, -1,   -1,    5,  -1,  1,   0,  0,   0));
        vecs.push_back(mk(5'b00001,  7, 50, -1,   -1,   -1,  -1,  1,   0,  0,   0));
        vecs.push_back(mk(5'b00000, -1,  0, -1,   -1,   -1,  -1,  1,   0,  0,   0));
        vecs.push_back(mk(5'b00011, -1,  0,  1,   -1,   -1,  -1,  0,   1,  1, 1024));
        vecs.push_back(mk(5'b01000, -1,  0, -1,   10,   -1,  -1,  0,   0,  0,   0));
        vecs.push_back(mk(5'b00001, -1,  0, -1,   -1,   -1,  -1,  1,   0,  0,   0));
        vecs.push_back(mk(5'b11111, -1,  0, -1,   -1,   -1,  -1,  1,   0,  0,   0));
`ifdef MHBF_CFG_CHECKSUM_EN
        vecs.push_back(mk(5'b00001, -1,  0, -1,   -1,   -1,   0,  0,   1,  0,   3));
`endif

        for (int i = 0; i < vecs.size(); i++) run_pass(i, vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
